// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register slave: FSM state encoding,
// error read-back pattern and the bus-word size helper.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERROR  = 2'd3
    } apb_slv_state_t;

    localparam logic [15:0] ERR_PATTERN = 16'hBAD1;

    // Only PADDR[11:0] takes part in decode.
    localparam int unsigned DEC_ADDR_W = 12;

    function automatic int unsigned BYTES_PER_WORD(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if_if.sv
// APB3 bus bundle between bridge (master) and register slave; PSTRB exists only
// when APB_SLV_STRB_EN is defined.
interface apb_reg_slave_if_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [31:0]             PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_SLV_STRB_EN
    logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

`ifdef APB_SLV_STRB_EN
    modport master (
        output PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PADDR, PWDATA, PSTRB, PSEL, PENABLE, PWRITE,
        output PRDATA, PREADY, PSLVERR
    );
`else
    modport master (
        output PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PADDR, PWDATA, PSEL, PENABLE, PWRITE,
        output PRDATA, PREADY, PSLVERR
    );
`endif

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational register decode of PADDR[11:0]: match, index, one-hot select,
// misalignment and read-only write violation. Zero latency, no backpressure.
module apb_addr_decode
    import apb_slave_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          NUM_REGS    = 4,
    parameter logic [11:0]          ADDR_OFFSET = 12'h000,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    localparam int unsigned         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [DEC_ADDR_W-1:0] paddr,
    input  logic                  pwrite,
    output logic                  match,
    output logic [IDX_W-1:0]      index,
    output logic [NUM_REGS-1:0]   sel,
    output logic                  misalign,
    output logic                  ro_violation
);

    localparam int unsigned WORD_BYTES = BYTES_PER_WORD(DATA_WIDTH);
    localparam int unsigned LSB_W      = $clog2(WORD_BYTES);

    logic [DEC_ADDR_W:0]   rel;
    logic [DEC_ADDR_W-1:0] word_idx;

    always_comb begin
        // rel[12] set means the address lies below register 0.
        rel      = {1'b0, paddr} - {1'b0, ADDR_OFFSET};
        word_idx = rel[DEC_ADDR_W-1:0] >> LSB_W;
        misalign = |paddr[LSB_W-1:0];
        match    = !rel[DEC_ADDR_W]
                   && (rel[LSB_W-1:0] == '0)
                   && (word_idx < DEC_ADDR_W'(NUM_REGS));
        sel      = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = match && (word_idx == DEC_ADDR_W'(i));
        end
        index        = word_idx[IDX_W-1:0];
        ro_violation = pwrite && |(sel & RO_MASK);
    end

endmodule

// File: rtl/apb_reg_slave_if.sv
// APB3 slave front-end for a peripheral register file; 2+WAIT_STATES cycles per valid
// transfer (errors 2), PREADY held low during waits. Byte strobes with APB_SLV_STRB_EN.
module apb_reg_slave_if
    import apb_slave_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          NUM_REGS    = 4,
    parameter logic [11:0]          ADDR_OFFSET = 12'h000,
    parameter int unsigned          WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    localparam int unsigned         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned         STRB_W      = DATA_WIDTH / 8
) (
    input  logic                                 clk,
    input  logic                                 n_rst,
    apb_reg_slave_if_if.slave                    apb,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  read_data,
    output logic [NUM_REGS-1:0]                  w_enable,
    output logic [NUM_REGS-1:0]                  r_enable,
    output logic [DATA_WIDTH-1:0]                w_data,
    output logic [STRB_W-1:0]                    w_strb
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    apb_slv_state_t        state;
    apb_slv_state_t        state_nxt;
    logic [3:0]            wait_cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_REGS-1:0]   sel_q;
    logic                  write_q;

    logic                  setup;
    logic                  dec_match;
    logic [IDX_W-1:0]      dec_index;
    logic [NUM_REGS-1:0]   dec_sel;
    logic                  dec_misalign;
    logic                  dec_ro;
    logic                  dec_err;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^apb.PADDR[31:DEC_ADDR_W];
    assign setup          = apb.PSEL && !apb.PENABLE;
    assign dec_err        = !dec_match || dec_misalign || dec_ro;

    apb_addr_decode #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_REGS    (NUM_REGS),
        .ADDR_OFFSET (ADDR_OFFSET),
        .RO_MASK     (RO_MASK)
    ) u_addr_decode (
        .paddr        (apb.PADDR[DEC_ADDR_W-1:0]),
        .pwrite       (apb.PWRITE),
        .match        (dec_match),
        .index        (dec_index),
        .sel          (dec_sel),
        .misalign     (dec_misalign),
        .ro_violation (dec_ro)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // PENABLE without a preceding setup never qualifies here.
                if (setup) begin
                    if (dec_err) begin
                        state_nxt = ST_ERROR;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = ST_ACCESS;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            sel_q    <= '0;
            write_q  <= 1'b0;
            w_data   <= '0;
        end else if (state == ST_IDLE && setup) begin
            wait_cnt <= WAIT_LOAD;
            idx_q    <= dec_index;
            sel_q    <= dec_sel;
            write_q  <= apb.PWRITE;
            w_data   <= apb.PWDATA;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

`ifdef APB_SLV_STRB_EN
    // Strobes reset to all-ones so an unconfigured consumer sees full-word writes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w_strb <= '1;
        end else if (state == ST_IDLE && setup) begin
            w_strb <= apb.PSTRB;
        end
    end
`else
    assign w_strb = '1;
`endif

    always_comb begin
        apb.PRDATA  = '0;
        apb.PREADY  = 1'b0;
        apb.PSLVERR = 1'b0;
        w_enable    = '0;
        r_enable    = '0;
        case (state)
            ST_ACCESS: begin
                // A dropped PSEL here is an abort: no response, no strobe.
                if (apb.PSEL) begin
                    apb.PREADY = 1'b1;
                    if (write_q) begin
                        w_enable = sel_q;
                    end else begin
                        r_enable   = sel_q;
                        apb.PRDATA = read_data[idx_q];
                    end
                end
            end
            ST_ERROR: begin
                apb.PREADY  = 1'b1;
                apb.PSLVERR = 1'b1;
                apb.PRDATA  = {(DATA_WIDTH / 16){ERR_PATTERN}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_reg_slave_if.sv
// Three differently configured slaves share one APB master; each response is checked
// against an arithmetic decode/latency model of the register map.
module tb_apb_reg_slave_if;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [31:0] paddr = '0;
    logic [63:0] pwdata = '0;
    logic [7:0]  pstrb = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Configuration of slaves 0..2 as the model sees it.
    int          cfg_dw   [3] = '{32, 32, 64};
    int          cfg_n    [3] = '{4, 5, 3};
    int          cfg_off  [3] = '{'h000, 'h100, 'h040};
    int          cfg_ws   [3] = '{0, 3, 2};
    logic [7:0]  cfg_ro   [3] = '{8'b0001, 8'b10010, 8'b100};

    apb_reg_slave_if_if #(.DATA_WIDTH(32)) bus0 ();
    apb_reg_slave_if_if #(.DATA_WIDTH(32)) bus1 ();
    apb_reg_slave_if_if #(.DATA_WIDTH(64)) bus2 ();

    assign bus0.PADDR = paddr;  assign bus0.PWDATA = pwdata[31:0];
    assign bus0.PSEL  = psel;   assign bus0.PENABLE = penable; assign bus0.PWRITE = pwrite;
    assign bus1.PADDR = paddr;  assign bus1.PWDATA = pwdata[31:0];
    assign bus1.PSEL  = psel;   assign bus1.PENABLE = penable; assign bus1.PWRITE = pwrite;
    assign bus2.PADDR = paddr;  assign bus2.PWDATA = pwdata;
    assign bus2.PSEL  = psel;   assign bus2.PENABLE = penable; assign bus2.PWRITE = pwrite;
`ifdef APB_SLV_STRB_EN
    assign bus0.PSTRB = pstrb[3:0];
    assign bus1.PSTRB = pstrb[3:0];
    assign bus2.PSTRB = pstrb;
`endif

    logic [3:0][31:0] rd0;
    logic [4:0][31:0] rd1;
    logic [2:0][63:0] rd2;
    logic [3:0]  wen0, ren0;  logic [31:0] wd0;  logic [3:0] wsb0;
    logic [4:0]  wen1, ren1;  logic [31:0] wd1;  logic [3:0] wsb1;
    logic [2:0]  wen2, ren2;  logic [63:0] wd2;  logic [7:0] wsb2;

    apb_reg_slave_if #(.DATA_WIDTH(32), .NUM_REGS(4), .ADDR_OFFSET(12'h000),
                       .WAIT_STATES(0), .RO_MASK(4'b0001)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .apb(bus0), .read_data(rd0),
        .w_enable(wen0), .r_enable(ren0), .w_data(wd0), .w_strb(wsb0));

    apb_reg_slave_if #(.DATA_WIDTH(32), .NUM_REGS(5), .ADDR_OFFSET(12'h100),
                       .WAIT_STATES(3), .RO_MASK(5'b10010)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .apb(bus1), .read_data(rd1),
        .w_enable(wen1), .r_enable(ren1), .w_data(wd1), .w_strb(wsb1));

    apb_reg_slave_if #(.DATA_WIDTH(64), .NUM_REGS(3), .ADDR_OFFSET(12'h040),
                       .WAIT_STATES(2), .RO_MASK(3'b100)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .apb(bus2), .read_data(rd2),
        .w_enable(wen2), .r_enable(ren2), .w_data(wd2), .w_strb(wsb2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode: plain byte arithmetic on the register map.
    function automatic void ref_decode(input int k, input logic [31:0] a, input logic w,
                                       output bit err, output int idx);
        int word, lo, rel;
        word = cfg_dw[k] / 8;
        lo   = int'(a[11:0]);
        idx  = 0;
        err  = 0;
        if ((lo % word) != 0 || lo < cfg_off[k]) begin
            err = 1;
        end else begin
            rel = lo - cfg_off[k];
            if ((rel % word) != 0) err = 1;
            else begin
                idx = rel / word;
                if (idx >= cfg_n[k]) err = 1;
                else if (w && cfg_ro[k][idx]) err = 1;
            end
        end
    endfunction

    function automatic logic [63:0] rd_val(input int k, input int idx);
        case (k)
            0:       return 64'(rd0[idx]);
            1:       return 64'(rd1[idx]);
            default: return rd2[idx];
        endcase
    endfunction

    task automatic check_dut(input int k, input string tag, input bit active, input bit err,
                             input logic w, input int idx, input logic [63:0] d,
                             input logic [7:0] s);
        logic [63:0] o_prdata, o_wen, o_ren, o_wd, e_prdata, e_wen, e_ren, dmask;
        logic [7:0]  o_strb, e_strb, smask;
        logic        o_ready, o_err;
        case (k)
            0: begin o_prdata = 64'(bus0.PRDATA); o_ready = bus0.PREADY; o_err = bus0.PSLVERR;
                     o_wen = 64'(wen0); o_ren = 64'(ren0); o_wd = 64'(wd0); o_strb = 8'(wsb0); end
            1: begin o_prdata = 64'(bus1.PRDATA); o_ready = bus1.PREADY; o_err = bus1.PSLVERR;
                     o_wen = 64'(wen1); o_ren = 64'(ren1); o_wd = 64'(wd1); o_strb = 8'(wsb1); end
            default: begin o_prdata = bus2.PRDATA; o_ready = bus2.PREADY; o_err = bus2.PSLVERR;
                     o_wen = 64'(wen2); o_ren = 64'(ren2); o_wd = wd2; o_strb = wsb2; end
        endcase
        dmask = (cfg_dw[k] == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
        smask = (cfg_dw[k] == 64) ? 8'hFF : 8'h0F;
        e_prdata = '0; e_wen = '0; e_ren = '0;
        if (active && err) e_prdata = 64'hBAD1_BAD1_BAD1_BAD1 & dmask;
        if (active && !err) begin
            if (w) e_wen = 64'd1 << idx;
            else begin e_ren = 64'd1 << idx; e_prdata = rd_val(k, idx); end
        end
        chk($sformatf("%s d%0d pready", tag, k), 64'(o_ready), 64'(active));
        chk($sformatf("%s d%0d pslverr", tag, k), 64'(o_err), 64'(active && err));
        chk($sformatf("%s d%0d prdata", tag, k), o_prdata, e_prdata);
        chk($sformatf("%s d%0d w_enable", tag, k), o_wen, e_wen);
        chk($sformatf("%s d%0d r_enable", tag, k), o_ren, e_ren);
        if (active && !err && w) begin
`ifdef APB_SLV_STRB_EN
            e_strb = s & smask;
`else
            e_strb = smask;
`endif
            chk($sformatf("%s d%0d w_data", tag, k), o_wd, d & dmask);
            chk($sformatf("%s d%0d w_strb", tag, k), 64'(o_strb), 64'(e_strb));
        end
        if (tag == "reset") begin
            chk($sformatf("reset d%0d w_data", k), o_wd, 64'd0);
            chk($sformatf("reset d%0d w_strb", k), 64'(o_strb), 64'(smask));
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] s, input int abort_at);
        bit err [3];
        int idx [3];
        int rc  [3];
        bit resp[3];
        int last, end_c;
        rd0 = {$urandom, $urandom, $urandom, $urandom};
        rd1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rd2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        last = 1;
        for (int k = 0; k < 3; k++) begin
            ref_decode(k, a, w, err[k], idx[k]);
            rc[k] = err[k] ? 1 : 1 + cfg_ws[k];
            if (rc[k] > last) last = rc[k];
        end
        if (abort_at > last) abort_at = 0;
        for (int k = 0; k < 3; k++)
            resp[k] = err[k] || (abort_at == 0) || (rc[k] < abort_at);
        paddr = a; pwrite = w; pwdata = d; pstrb = s; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_dut(k, "setup", 0, 0, w, 0, d, s);
        @(posedge clk); #1;
        end_c = (abort_at != 0) ? abort_at : last;
        for (int c = 1; c <= end_c; c++) begin
            penable = 1'b1;
            if (c == abort_at) begin psel = 1'b0; penable = 1'b0; end
            @(negedge clk);
            for (int k = 0; k < 3; k++)
                check_dut(k, $sformatf("a%03h w%0d c%0d", a[11:0], w, c),
                          (c == rc[k]) && resp[k], err[k], w, idx[k], d, s);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycle(input logic sel_v, input logic en_v);
        psel = sel_v; penable = en_v;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_dut(k, "idle", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic mid_wait_reset();
        paddr = 32'h0000_0100; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_dut(k, "reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_dut(k, "reset", 0, 0, 0, 0, 0, 0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle_cycle(0, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          off, ab;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_dut(k, "reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle_cycle(0, 0);

        xfer(32'h004, 1, 64'h0123_4567_DEAD_BEEF, 8'h0F, 0);
        xfer(32'h108, 0, 64'h0, 8'h0, 0);
        xfer(32'h010, 0, 64'h0, 8'h0, 0);
        xfer(32'h002, 0, 64'h0, 8'h0, 0);
        xfer(32'h000, 1, 64'h5555_AAAA, 8'hFF, 0);
        xfer(32'h000, 0, 64'h0, 8'h0, 0);
        xfer(32'h048, 0, 64'h0, 8'h0, 2);
        xfer(32'h000, 0, 64'h0, 8'h0, 0);
        idle_cycle(1, 1);
        xfer(32'h048, 1, 64'hCAFE_F00D_1234_5678, 8'h0F, 0);
        xfer(32'h050, 1, 64'h1, 8'hFF, 0);
        xfer(32'h110, 1, 64'h2, 8'h03, 0);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 2))
                0:       off = 'h000;
                1:       off = 'h040;
                default: off = 'h100;
            endcase
            off = off + int'($urandom_range(0, 47));
            case ($urandom_range(0, 3))
                1, 2:    off = off & ~3;
                3:       off = off & ~7;
                default: ;
            endcase
            a = {$urandom_range(0, 1) ? 20'($urandom) : 20'h0, 12'(off)};
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            xfer(a, 1'($urandom), {$urandom, $urandom}, 8'($urandom), ab);
            case ($urandom_range(0, 3))
                0:       idle_cycle(0, 0);
                1:       idle_cycle(1, 1);
                default: ;
            endcase
        end

        mid_wait_reset();
        xfer(32'h104, 0, 64'h0, 8'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/apb_reg_slave_if.md
# apb_reg_slave_if

Parametrised APB3 slave interface between the APB bridge and a peripheral register file, replacing the fixed 32-bit, zero-wait GPIO-style interface. Adds configurable data width, PREADY wait-state insertion, per-register read-only protection, misalignment and protocol-abort handling, and optional byte strobes. One instance sits in front of each peripheral's registers.

## Interface
- DATA_WIDTH, 32, bus and register width; 32 or 64.
- NUM_REGS, 4, registers owned; 1..64.
- ADDR_OFFSET, 12'h000, byte offset of register 0 within PADDR[11:0].
- WAIT_STATES, 0, PREADY-low cycles inserted per valid transfer; 0..15.
- RO_MASK, '0, NUM_REGS bits; bit i = 1 makes register i read-only.
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- PADDR  in  32  address; only [11:0] decoded
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte strobes (only with APB_SLV_STRB_EN)
- PSEL, PENABLE, PWRITE  in  1 each  APB control
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  error response
- read_data  in  [NUM_REGS][DATA_WIDTH]  register contents
- w_enable, r_enable  out  NUM_REGS  one-hot, single-cycle strobes
- w_data  out  DATA_WIDTH  PWDATA latched at setup
- w_strb  out  DATA_WIDTH/8  byte enables for write

## Operation
- States: IDLE, WAIT, ACCESS, ERROR.
- Setup detected in IDLE when PSEL=1, PENABLE=0. Latch index, PWRITE, PWDATA, PSTRB.
- Decode: word = DATA_WIDTH/8 bytes; register i at ADDR_OFFSET + i*word.
- Error if any of: no register matches; PADDR low log2(word) bits nonzero; write to a register with RO_MASK bit set.
- IDLE -> ERROR on error; -> ACCESS if WAIT_STATES=0; else -> WAIT with counter = WAIT_STATES-1.
- WAIT: counter decrements; at 0 -> ACCESS.
- ACCESS: PREADY=1. Write: w_enable[idx]=1. Read: r_enable[idx]=1 and PRDATA=read_data[idx]. Then -> IDLE.
- ERROR: PREADY=1, PSLVERR=1, PRDATA = 16'hBAD1 replicated to DATA_WIDTH, no enables. Then -> IDLE.
- Abort: PSEL=0 in WAIT or ACCESS -> IDLE. No enables pulse and no response is given.
- PENABLE=1 in IDLE without a prior setup is ignored.
- Back-to-back transfers: a setup in the cycle after ACCESS or ERROR is accepted normally.
- Outside ACCESS and ERROR: PRDATA=0, PREADY=0, PSLVERR=0, enables=0.

## Timing
- Reset: state IDLE, counter 0, all latches 0. Every output is 0, except w_strb, which resets to all-ones.
- Valid transfer: setup at cycle T. WAIT occupies T+1..T+N; ACCESS at T+1+N with PREADY high. Total 2+N cycles.
- Error transfer: always 2 cycles. WAIT_STATES is not applied.
- Enables are asserted only in the PREADY=1 cycle, never more than one cycle per transfer.
- The register file samples w_data/w_strb on the clk edge ending ACCESS.
- PRDATA is combinational from read_data during ACCESS.
- Reset mid-transfer returns to IDLE immediately. No enable is emitted.

## Configuration
- APB_SLV_STRB_EN defined: PSTRB port exists and is latched at setup; w_strb = latched PSTRB. A write with PSTRB=0 completes as a normal ACCESS, with w_enable pulsed and w_strb=0.
- APB_SLV_STRB_EN undefined: no PSTRB port; w_strb is constant all-ones.

## Structure
- Package apb_slave_pkg holds:
  - state enum apb_slv_state_t;
  - ERR_PATTERN constant (16'hBAD1);
  - BYTES_PER_WORD function of DATA_WIDTH.
- Sub-module apb_addr_decode (combinational) takes PADDR[11:0], PWRITE and the parameters, and returns match, index, one-hot select, misalign and ro_violation.
- The FSM, wait counter and latches live in apb_reg_slave_if.

## Test plan
- Defaults, write 32'hDEADBEEF to 0x004 -> w_enable=4'b0010 for one cycle, w_data=DEADBEEF, PREADY high on cycle 2, PSLVERR=0.
- WAIT_STATES=3, read 0x008 with read_data[2]=32'h12345678 -> PREADY low for 3 cycles, then high with PRDATA=12345678 and r_enable=4'b0100.
- Read 0x010 (unmapped), then 0x002 (misaligned) -> each gives PREADY=1, PSLVERR=1, PRDATA=BAD1BAD1, no enables.
- RO_MASK=4'b0001: write reg 0 -> PSLVERR=1, w_enable=0; read reg 0 -> success.
- WAIT_STATES=2, drop PSEL in the 2nd WAIT cycle -> IDLE, no enables. A following read of 0x000 completes normally.
- DATA_WIDTH=64 with APB_SLV_STRB_EN, write 0x008 with PSTRB=8'h0F -> w_enable[1]=1, w_strb=0F. n_rst low mid-WAIT -> all outputs 0 and w_strb all-ones.
